// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Operates on operand magnitudes; signs are applied to quotient and remainder once the last iteration is done.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem, quo, dvs;
  logic               neg_q, neg_r;
  logic [WIDTH:0]     trial;
  logic               start_ok, dvs_zero, last_iter;

  // Two's-complement negate when requested; the most-negative value maps to 2^(W-1) unsigned.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign start_ok  = start_i && !annul_i;
  assign dvs_zero  = (opdata2_i == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH));
  assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) state <= S_FREE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FREE:   if (start_ok) state_nx = dvs_zero ? S_BYZERO : S_ON;
      S_BYZERO: state_nx = S_END;
      S_ON: begin
        if (annul_i)        state_nx = S_FREE;
        else if (last_iter) state_nx = S_END;
      end
      S_END:    if (!start_i) state_nx = S_FREE;
      default:  state_nx = S_FREE;
    endcase
  end

  // Datapath: operand capture, one restoring step per edge, then sign fix into the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_ok && !dvs_zero) begin
            neg_r <= signed_div_i && opdata1_i[WIDTH-1];
            neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            quo   <= cond_neg(opdata1_i, signed_div_i && opdata1_i[WIDTH-1]);
            dvs   <= cond_neg(opdata2_i, signed_div_i && opdata2_i[WIDTH-1]);
            rem   <= '0;
            cnt   <= '0;
          end
        end
        S_BYZERO: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
        S_ON: begin
          if (annul_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (!last_iter) begin
            if (trial[WIDTH]) begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {cond_neg(rem, neg_r), cond_neg(quo, neg_q)};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          // The divide-by-zero path arrives here with ready low; it rises one edge later.
          if (start_i) begin
            ready_o <= 1'b1;
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule
